alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Derived constant SHW = log2(WIDTH): width of the shift amount.
REQ-003 clk  input  1  rising-edge clock; the block uses one clock; reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 op  input  4  opcode; see REQ-010.
REQ-008 a, b  input  WIDTH each  operands; b[SHW-1:0] is the shift amount for shift ops.
REQ-009 result  output  WIDTH  result data.
REQ-009a flags  output  4  {err, ovf, carry, zero}.
REQ-009b out_valid  output  1  result and flags are valid.
REQ-009c out_ready  input  1  consumer accepts the result.

Function
REQ-010 Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- 5 SLT (signed), 6 SLTU (unsigned); both return 0 or 1 zero-extended.
- 7 SLL, 8 SRL, 9 SRA.
- 10 MUL: low WIDTH bits of the unsigned product.
- 11-15 illegal.
REQ-011 State machine has three states: IDLE, BUSY, DONE.
REQ-012 in_ready = 1 only in IDLE.
REQ-013 A transfer occurs when in_valid and in_ready are both 1; op, a and b are captured on that edge.
REQ-014 Single-cycle ops (0-6, illegal):
- IDLE -> DONE on transfer.
- out_valid rises on the next edge after transfer: latency 1.
REQ-015 Shift ops:
- IDLE -> BUSY on transfer.
- One bit position per cycle; an internal counter is loaded with b[SHW-1:0].
- BUSY -> DONE when the counter reaches 0.
- Latency = 1 + shamt; shamt 0 gives latency 1.
REQ-016 SRA fills with the captured a[WIDTH-1]; SLL and SRL fill with 0.
REQ-017 MUL:
- Shift-add, one multiplier bit per cycle.
- Latency = WIDTH + 1, fixed regardless of operand values.
REQ-018 DONE:
- Result and flags are held stable while out_valid = 1 and out_ready = 0.
- DONE -> IDLE on out_valid and out_ready both 1.
- No new operation is accepted in the same cycle as the DONE -> IDLE transition.
REQ-019 ADD/SUB arithmetic:
- SUB computes a + ~b + 1.
- carry = carry-out of bit WIDTH-1; for SUB, carry = 1 means no borrow.
- ovf = signed overflow.
REQ-020 For all other ops, carry = 0 and ovf = 0.
REQ-021 zero = 1 when result == 0, for every legal op.
REQ-022 Illegal op: result = 0, err = 1, zero = 0, and latency 1.
REQ-023 All arithmetic is modulo 2^WIDTH; there are no X outputs for any input value.
REQ-024 in_valid is ignored in BUSY and DONE; operands presented then are not captured.

Reset
REQ-025 While rst = 1: state = IDLE, out_valid = 0, result = 0, flags = 0, counters = 0.
REQ-026 in_ready = 1 in the first cycle after rst is released.
REQ-027 rst asserted in BUSY or DONE aborts the operation; no out_valid is produced for it.
REQ-028 rst has priority over every transfer in the same cycle.

Structure
REQ-029 Shared package alu_pkg holds:
- the opcode enum (4 bits);
- the state enum;
- flag bit index constants.
REQ-030 One sub-module, alu_add_w, is a WIDTH-parametrised adder (a, b, cin -> sum, cout).
- It serves ADD, SUB, SLT/SLTU and the MUL accumulate step.
REQ-031 The shifter and multiplier share one WIDTH-bit working register and one counter.

Verification
REQ-032 ADD 0xFFFFFFFF + 0x00000001 (WIDTH=32) -> result 0, carry 1, zero 1, ovf 0, out_valid 1 cycle after transfer.
REQ-033 SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, ovf 1, carry 1; SLT 0xFFFFFFFF, 0x1 -> 1; SLTU with the same operands -> 0.
REQ-034 SRA 0x80000000 by 4 -> 0xF8000000 on the 5th cycle after transfer; SLL by 0 -> a unchanged, latency 1.
REQ-035 MUL 0x0000FFFF * 0x00010001 -> 0xFFFFFFFF, out_valid on cycle 33; out_ready held 0 for 5 cycles -> result stable, in_ready 0 throughout.
REQ-036 rst pulsed in cycle 10 of a MUL -> no out_valid; in_ready 1 on the next cycle; a following ADD 2 + 3 -> 5.
REQ-037 op 13 -> result 0, err 1, latency 1; back-to-back ops with out_ready tied 1 -> one op per 2 cycles, never overlapped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

endpackage

// File: rtl/alu_add_w.sv
// WIDTH-bit ripple adder with carry in/out, shared by ADD/SUB/SLT/SLTU and the MUL accumulate step.
module alu_add_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: logic/add ops finish in one cycle, shifts move one bit per cycle, MUL is shift-add.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1, on either side.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q;
  op_e              op_q;
  logic             fill_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] mcand_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_add;
  logic             slt_lt;
  logic             sltu_lt;
  logic             illegal;
  logic             is_shift;
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_flags;
  logic [WIDTH-1:0] shift_next;

  // In BUSY the adder accumulates the partial product; otherwise it serves the incoming op.
  always_comb begin
    add_a   = a;
    add_b   = b;
    add_cin = 1'b0;
    if (state_q == ST_BUSY) begin
      add_a = result_q;
      add_b = mcand_q & {WIDTH{work_q[0]}};
    end else if (op == OP_SUB || op == OP_SLT || op == OP_SLTU) begin
      add_b   = ~b;
      add_cin = 1'b1;
    end
  end

  alu_add_w #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

  assign ovf_add  = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign slt_lt   = sum[WIDTH-1] ^ ovf_add;
  assign sltu_lt  = ~cout;
  assign illegal  = (op > OP_LAST_LEGAL);
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    sc_result = '0;
    sc_flags  = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_result           = sum;
        sc_flags[FLAG_CARRY] = cout;
        sc_flags[FLAG_OVF]   = ovf_add;
      end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, sltu_lt};
      default: sc_result = '0;
    endcase
    sc_flags[FLAG_ERR]  = illegal;
    sc_flags[FLAG_ZERO] = !illegal && (sc_result == '0);
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_next = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_next = {fill_q, work_q[WIDTH-1:1]};
      default: shift_next = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  // The counter holds the number of steps still to go after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      fill_q   <= 1'b0;
      work_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= op_e'(op);
            fill_q <= a[WIDTH-1];
            if (is_shift) begin
              if (b[SHW-1:0] == '0) begin
                result_q <= a;
                flags_q  <= {3'b000, (a == '0)};
                state_q  <= ST_DONE;
              end else begin
                work_q  <= a;
                cnt_q   <= b[SHW-1:0] - 1'b1;
                state_q <= ST_BUSY;
              end
            end else if (op == OP_MUL) begin
              work_q   <= b;
              mcand_q  <= a;
              result_q <= '0;
              cnt_q    <= SHW'(WIDTH - 1);
              state_q  <= ST_BUSY;
            end else begin
              result_q <= sc_result;
              flags_q  <= sc_flags;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (op_q == OP_MUL) begin
            result_q <= sum;
            mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
            work_q   <= {1'b0, work_q[WIDTH-1:1]};
            flags_q  <= {3'b000, (sum == '0)};
          end else begin
            work_q   <= shift_next;
            result_q <= shift_next;
            flags_q  <= {3'b000, (shift_next == '0)};
          end
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=32): hand-computed results, flags and latencies.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency (transfer edge counts as 1), check outputs,
  // optionally stall the consumer for hold cycles, then accept the result.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res,
                       input logic [3:0] exp_flags, input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    out_ready = 1'b0;
    step();
    lat = 1;
    // Operands offered while busy must be ignored.
    while (!out_valid && lat < 100) begin
      in_valid = 1'b1;
      op = 4'($urandom_range(0, 6));
      a = $urandom;
      b = $urandom;
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " flags"}, 64'(flags), 64'(exp_flags));
    held = result;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold result"}, 64'(result), 64'(exp_res));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " stable"}, 64'(held), 64'(exp_res));
  endtask

  initial begin
    int seen;
    int taken;
    int outs;
    int overlap;
    logic [31:0] exp_v;

    rst = 1'b1;
    in_valid = 1'b0;
    op = 4'd0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    repeat (3) step();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    step();
    check("post reset in_ready", 64'(in_ready), 64'd1);

    do_op("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0011, 1, 0);
    do_op("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0100, 1, 0);
    do_op("sub ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0110, 1, 0);
    do_op("sub zero", OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0011, 1, 0);
    do_op("sub borrow", OP_SUB, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0000, 1, 0);
    do_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000, 1, 0);
    do_op("or", OP_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b0000, 1, 0);
    do_op("xor", OP_XOR, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 4'b0001, 1, 0);
    do_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1, 0);
    do_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0001, 1, 0);
    do_op("sra 4", OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 4'b0000, 5, 0);
    do_op("sll 0", OP_SLL, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000, 1, 0);
    do_op("sll 31", OP_SLL, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 4'b0000, 32, 0);
    do_op("srl 31", OP_SRL, 32'h8000_0001, 32'h0000_001F, 32'h0000_0001, 4'b0000, 32, 0);
    do_op("srl zero", OP_SRL, 32'h0000_0010, 32'h0000_0005, 32'h0000_0000, 4'b0001, 6, 0);
    do_op("sra pos", OP_SRA, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 4'b0000, 3, 0);
    do_op("mul", OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4'b0000, 33, 5);
    do_op("mul zero", OP_MUL, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 4'b0001, 33, 0);
    do_op("mul wrap", OP_MUL, 32'h8000_0001, 32'h0000_0006, 32'h0000_0006, 4'b0000, 33, 0);
    do_op("illegal 13", 4'd13, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1, 0);
    do_op("illegal 15", 4'd15, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1000, 1, 0);

    // Reset in cycle 10 of a MUL aborts it.
    in_valid = 1'b1;
    op = OP_MUL;
    a = 32'h0000_FFFF;
    b = 32'h0001_0001;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("abort busy", 64'(dbg_state), 64'(ST_BUSY));
    rst = 1'b1;
    in_valid = 1'b1;
    op = OP_ADD;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort result", 64'(result), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort no valid", 64'(seen), 64'd0);
    do_op("add after abort", OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1, 0);

    // Back-to-back ADDs with the consumer always ready.
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = OP_ADD;
    taken = 0;
    outs = 0;
    overlap = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 16 + 7);
      b = 32'h0000_0001;
      if (in_ready) begin
        exp_q.push_back(a + 32'd1);
        taken++;
      end
      step();
      if (out_valid && in_ready) overlap++;
      if (out_valid) begin
        outs++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("b2b result", 64'(result), 64'(exp_v));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b accepted", 64'(taken), 64'd4);
    check("b2b outputs", 64'(outs), 64'd4);
    check("b2b overlap", 64'(overlap), 64'd0);
    check("b2b queue empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
